// File: rtl/alu_pkg.sv
// alu_pkg: shared word width, sequencer state encoding and clog2 helper.
// Build option: ALU_ADD_ARB_SUB_EN adds the INC state used by two-pass subtract.
package alu_pkg;
    localparam int WORD_W = 64;
`ifdef ALU_ADD_ARB_SUB_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, INC = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd3} state_t;
`endif
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/add_64.sv
// ADD_64: 64-bit ripple-carry adder.
// Ports: a, b operands; cin carry in; sum = a + b + cin (mod 2^64).
module ADD_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum
);
    logic [63:0] c;
    assign c[0] = cin;
    for (genvar i = 1; i < 64; i++) begin : g_rip
        assign c[i] = (a[i-1] & b[i-1]) | (c[i-1] & (a[i-1] ^ b[i-1]));
    end
    assign sum = a ^ b ^ c;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr.
// Ports: req request vector; ptr search start; en gate; gnt one-hot grant; idx grant index.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   s;
    // Rotate so bit 0 is the requester at ptr; the lowest set bit then wins.
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) if (rot[k]) off = W'(k);
    end
    assign s   = {1'b0, ptr} + {1'b0, off};
    assign idx = (s >= (W+1)'(N)) ? W'(s - (W+1)'(N)) : W'(s);
    assign gnt = (en && |req) ? (N'(1) << idx) : '0;
endmodule

// File: rtl/alu_add_arbiter.sv
// alu_add_arbiter: round-robin sharing of one ADD_64 between N_REQ requesters.
// Ports: req_valid/req_ready/req_a/req_b/req_op request handshake (64-bit lanes packed
// per requester); rsp_valid/rsp_ready handshake with rsp_id, rsp_sum, rsp_zf/sf/of.
// Build option: ALU_ADD_ARB_SUB_EN enables subtract as a + ~b followed by +1.
module alu_add_arbiter
    import alu_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [WORD_W*N_REQ-1:0] req_a,
    input  logic [WORD_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]        req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [WORD_W-1:0]       rsp_sum,
    output logic                    rsp_zf,
    output logic                    rsp_sf,
    output logic                    rsp_of
);
    state_t            state, nxt;
    logic [ID_W-1:0]   rr_ptr, gidx, id_q;
    logic [WORD_W-1:0] a_q, b_q, ax, bx, sum;
    logic              xfer, to_resp, of_n;
`ifdef ALU_ADD_ARB_SUB_EN
    logic              op_q;
`else
    logic              unused_op;
    assign unused_op = ^req_op;
`endif

    rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr),
        .en (state == IDLE && rst_n),
        .gnt(req_ready),
        .idx(gidx)
    );

    ADD_64 u_add (.a(ax), .b(bx), .cin(1'b0), .sum(sum));

    assign xfer = |req_ready;

    always_comb begin
        nxt = state;
        ax  = a_q;
        bx  = b_q;
        case (state)
            IDLE: nxt = xfer ? CALC : IDLE;
`ifdef ALU_ADD_ARB_SUB_EN
            CALC: begin
                bx  = op_q ? ~b_q : b_q;
                nxt = op_q ? INC : RESP;
            end
            INC: begin
                ax  = rsp_sum;
                bx  = 64'd1;
                nxt = RESP;
            end
`else
            CALC: nxt = RESP;
`endif
            RESP: nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    assign to_resp = nxt == RESP && state != RESP;
    // For subtract the effective second operand is ~b, so the sign test inverts.
`ifdef ALU_ADD_ARB_SUB_EN
    assign of_n = (op_q ? a_q[63] != b_q[63] : a_q[63] == b_q[63]) && sum[63] != a_q[63];
`else
    assign of_n = a_q[63] == b_q[63] && sum[63] != a_q[63];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
`ifdef ALU_ADD_ARB_SUB_EN
            op_q      <= 1'b0;
`endif
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_zf    <= 1'b0;
            rsp_sf    <= 1'b0;
            rsp_of    <= 1'b0;
        end else begin
            state <= nxt;
            if (xfer) begin
                a_q    <= req_a[WORD_W*int'(gidx) +: WORD_W];
                b_q    <= req_b[WORD_W*int'(gidx) +: WORD_W];
                id_q   <= gidx;
`ifdef ALU_ADD_ARB_SUB_EN
                op_q   <= req_op[gidx];
`endif
                rr_ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            if (state != IDLE && state != RESP) rsp_sum <= sum;
            if (to_resp) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_q;
                rsp_zf    <= sum == '0;
                rsp_sf    <= sum[63];
                rsp_of    <= of_n;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_add_arbiter.sv
// tb_alu_add_arbiter: directed and randomized checks of the shared-adder arbiter.
module tb_alu_add_arbiter;
    localparam int N = 4;
`ifdef ALU_ADD_ARB_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready, req_op;
    logic [64*N-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [63:0]    rsp_sum;
    logic           rsp_zf, rsp_sf, rsp_of;
    logic [63:0]    ra [N];
    logic [63:0]    rb [N];
    int             checks = 0;
    int             errors = 0;
    int             ptr = 0;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_a[64*i +: 64] = ra[i];
        assign req_b[64*i +: 64] = rb[i];
    end

    alu_add_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference grant: first valid requester at or after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_sum"},   rsp_sum,        64'd0);
        chk({tag, "_id"},    64'(rsp_id),    64'd0);
        chk({tag, "_flags"}, 64'({rsp_zf, rsp_sf, rsp_of}), 64'd0);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    endtask

    // Entered with the DUT idle, 1 time unit after a rising edge.
    task automatic run_op(input logic [N-1:0] mask, input bit keep, input int bp);
        int g, cyc;
        bit sub, of;
        logic [63:0] a, b, e;
        logic [N-1:0] oh;
        logic signed [65:0] full;
        req_valid = mask;
        #1;
        g = pick(mask);
        oh = '0;
        oh[g] = 1'b1;
        chk("grant", 64'(req_ready), 64'(oh));
        a = ra[g];
        b = rb[g];
        sub = SUB_EN && req_op[g];
        e = sub ? a - b : a + b;
        if (sub) full = $signed({a[63], a[63], a}) - $signed({b[63], b[63], b});
        else     full = $signed({a[63], a[63], a}) + $signed({b[63], b[63], b});
        of = full != $signed({e[63], e[63], e});
        @(posedge clk);
        #1;
        ptr = (g + 1) % N;
        cyc = 1;
        if (!keep) req_valid = '0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 64'(cyc), sub ? 64'd3 : 64'd2);
        chk("sum", rsp_sum, e);
        chk("id", 64'(rsp_id), 64'(g));
        chk("zf", 64'(rsp_zf), 64'(e == 64'd0));
        chk("sf", 64'(rsp_sf), 64'(e[63]));
        chk("of", 64'(rsp_of), 64'(of));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_sum", rsp_sum, e);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        req_valid = '1;
        req_op = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            ra[k] = '0;
            rb[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        ra[0] = 64'd5;
        rb[0] = 64'd7;
        run_op(4'b0001, 1'b0, 0);
        ra[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        rb[1] = 64'd1;
        run_op(4'b0010, 1'b0, 0);
        ra[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        rb[2] = 64'd1;
        run_op(4'b0100, 1'b0, 0);
        ra[3] = 64'd3;
        rb[3] = 64'd5;
        req_op = 4'b1000;
        run_op(4'b1000, 1'b0, 0);
        req_op = '0;
        for (int k = 0; k < N; k++) begin
            ra[k] = {$urandom, $urandom};
            rb[k] = {$urandom, $urandom};
        end
        for (int k = 0; k < 5; k++) run_op(4'hF, 1'b1, 0);
        req_valid = '0;
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N; k++) begin
                ra[k] = ($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
                rb[k] = ($urandom_range(0, 3) == 0) ? ra[k] : {$urandom, $urandom};
            end
            req_op = N'($urandom);
            run_op(N'($urandom_range(1, 15)), 1'b0, $urandom_range(0, 3));
        end
        req_op = 4'b0110;
        run_op(4'b0110, 1'b0, 10);
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("no_rsp", 64'(rsp_valid), 64'd0);
        end
        req_op = '0;
        run_op(4'hF, 1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
